// File: rtl/hdr_capture.sv
// rtl/hdr_capture.sv - Ingress header capture stage ahead of the packet parser
// Purpose:
//   Collects the first HEADER_BYTES bytes of each ingress packet into a flat
//   vector and pulses header_done. It then holds that vector until the parser
//   returns parse_done. Payload beyond the header window is accepted and
//   dropped. The next packet is back-pressured while the parser works.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   s_tdata/s_tkeep   ingress beat data and byte-valid lanes (lane 0 first)
//   s_tvalid/s_tlast  beat valid, last beat of packet
//   s_tready          beat accept (0 while holding a header or in reset)
//   parse_done        parser pulse releasing the held header
//   header_done       one-cycle pulse: header_flat/hdr_len are valid
//   header_flat       packet byte i at [i*8 +: 8], unwritten bytes read 0
//   hdr_len           number of valid header bytes
//   hdr_full          header window filled and the packet continued past it
//   timeout_err       sticky parser-timeout flag
// Optional feature macro: HDR_CAP_TIMEOUT_EN (PARSE_TIMEOUT release counter).

module hdr_capture #(
    parameter int HEADER_BYTES  = 192,
    parameter int BEAT_BYTES    = 8,
    parameter int PTR_W         = 8,
    parameter int PARSE_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [8*BEAT_BYTES-1:0]   s_tdata,
    input  logic [BEAT_BYTES-1:0]     s_tkeep,
    input  logic                      s_tvalid,
    input  logic                      s_tlast,
    output logic                      s_tready,
    input  logic                      parse_done,
    output logic                      header_done,
    output logic [8*HEADER_BYTES-1:0] header_flat,
    output logic [PTR_W-1:0]          hdr_len,
    output logic                      hdr_full,
    output logic                      timeout_err
);

    if (((HEADER_BYTES % BEAT_BYTES) != 0) || (HEADER_BYTES >= (1 << PTR_W)) ||
        (PARSE_TIMEOUT < 1)) begin : g_bad_cfg
        $error("hdr_capture: invalid parameter set");
    end

    localparam logic [PTR_W:0] HDR_MAX = (PTR_W+1)'(HEADER_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_DRAIN,
        ST_HOLD
    } state_t;

    state_t                    r_state;
    state_t                    w_state_next;
    logic [8*HEADER_BYTES-1:0] r_flat;
    logic [8*HEADER_BYTES-1:0] w_flat_next;
    logic [8*HEADER_BYTES-1:0] w_flat_merge;
    logic [PTR_W-1:0]          r_len;
    logic [PTR_W-1:0]          w_len_next;
    logic [PTR_W-1:0]          w_new_len;
    logic [PTR_W:0]            w_pop;
    logic [PTR_W:0]            w_sum;
    logic                      w_reached;
    logic                      r_full;
    logic                      w_full_next;
    logic                      r_done;
    logic                      w_done_next;
    logic                      r_pd_seen;
    logic                      w_pd_next;
    logic                      w_accept;
    logic                      w_expire;
    logic                      w_release;

    assign s_tready = rst_n && (r_state != ST_HOLD);
    assign w_accept = s_tvalid && s_tready;

    // keep is contiguous from lane 0, so the byte count of a beat is its popcount
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < BEAT_BYTES; k++) begin
            w_pop = w_pop + (PTR_W+1)'(s_tkeep[k]);
        end
    end

    // r_len is 0 whenever the state is IDLE, so it is also the write offset
    // for the first beat of a packet.
    assign w_sum     = {1'b0, r_len} + w_pop;
    assign w_reached = (w_sum >= HDR_MAX);
    assign w_new_len = w_reached ? HDR_MAX[PTR_W-1:0] : w_sum[PTR_W-1:0];

    // Drop incoming lanes into the header at byte offset r_len; bytes that
    // would fall past the window are discarded.
    always_comb begin
        w_flat_merge = r_flat;
        for (int i = 0; i < HEADER_BYTES; i++) begin
            for (int k = 0; k < BEAT_BYTES; k++) begin
                if (s_tkeep[k] && ((int'(r_len) + k) == i)) begin
                    w_flat_merge[i*8 +: 8] = s_tdata[k*8 +: 8];
                end
            end
        end
    end

`ifdef HDR_CAP_TIMEOUT_EN
    logic [15:0] r_to_cnt;
    logic        r_to_err;
    logic        w_to_run;

    // Counting stops in DRAIN once a release is already recorded.
    assign w_to_run = (r_state == ST_HOLD) || ((r_state == ST_DRAIN) && !r_pd_seen);
    assign w_expire = w_to_run && (r_to_cnt == 16'(PARSE_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else begin
            if (w_state_next != r_state) begin
                r_to_cnt <= '0;
            end else if (w_to_run) begin
                r_to_cnt <= r_to_cnt + 16'd1;
            end
            if (w_expire && !parse_done) begin
                r_to_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_to_err;
`else
    assign w_expire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    assign w_release = parse_done || w_expire;

    always_comb begin
        w_state_next = r_state;
        w_flat_next  = r_flat;
        w_len_next   = r_len;
        w_full_next  = r_full;
        w_pd_next    = r_pd_seen;
        w_done_next  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // An empty beat (with or without last) leaves the block idle.
                if (w_accept && (w_pop != '0)) begin
                    w_flat_next = w_flat_merge;
                    w_len_next  = w_new_len;
                    w_full_next = 1'b0;
                    if (s_tlast) begin
                        w_state_next = ST_HOLD;
                        w_done_next  = 1'b1;
                    end else if (w_reached) begin
                        w_state_next = ST_DRAIN;
                        w_full_next  = 1'b1;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next = ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (w_accept) begin
                    w_flat_next = w_flat_merge;
                    w_len_next  = w_new_len;
                    if (s_tlast) begin
                        w_state_next = ST_HOLD;
                        w_done_next  = 1'b1;
                    end else if (w_reached) begin
                        w_state_next = ST_DRAIN;
                        w_full_next  = 1'b1;
                        w_done_next  = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (w_release) begin
                    w_pd_next = 1'b1;
                end
                if (w_accept && s_tlast) begin
                    // Parser already finished: skip HOLD entirely.
                    if (r_pd_seen || w_release) begin
                        w_state_next = ST_IDLE;
                        w_flat_next  = '0;
                        w_len_next   = '0;
                        w_pd_next    = 1'b0;
                    end else begin
                        w_state_next = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (w_release) begin
                    w_state_next = ST_IDLE;
                    w_flat_next  = '0;
                    w_len_next   = '0;
                    w_pd_next    = 1'b0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_flat    <= '0;
            r_len     <= '0;
            r_full    <= 1'b0;
            r_done    <= 1'b0;
            r_pd_seen <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_flat    <= w_flat_next;
            r_len     <= w_len_next;
            r_full    <= w_full_next;
            r_done    <= w_done_next;
            r_pd_seen <= w_pd_next;
        end
    end

    assign header_done = r_done;
    assign header_flat = r_flat;
    assign hdr_len     = r_len;
    assign hdr_full    = r_full;

endmodule

// File: tb/tb_hdr_capture.sv
// tb/tb_hdr_capture.sv - Self-checking bench for hdr_capture
module tb_hdr_capture;

    localparam int HB = 192;
    localparam int BB = 8;
    localparam int PW = 8;
    localparam int PT = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [8*BB-1:0] s_tdata;
    logic [BB-1:0]   s_tkeep;
    logic            s_tvalid;
    logic            s_tlast;
    logic            s_tready;
    logic            parse_done;
    logic            header_done;
    logic [8*HB-1:0] header_flat;
    logic [PW-1:0]   hdr_len;
    logic            hdr_full;
    logic            timeout_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hdr_capture #(
        .HEADER_BYTES (HB),
        .BEAT_BYTES   (BB),
        .PTR_W        (PW),
        .PARSE_TIMEOUT(PT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_tdata    (s_tdata),
        .s_tkeep    (s_tkeep),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .parse_done (parse_done),
        .header_done(header_done),
        .header_flat(header_flat),
        .hdr_len    (hdr_len),
        .hdr_full   (hdr_full),
        .timeout_err(timeout_err)
    );

    // Plays one packet of nbytes random bytes and checks it against a
    // packet-level model: the header is the first min(nbytes,HB) bytes, it is
    // announced on the beat that completes it, and the stream is stalled only
    // once the packet is over, the header is out and parse_done has not come.
    // pd_delay: cycles after the header_done cycle at which parse_done pulses.
    // silent: the pulse is only modelled (timeout build), never driven.
    task automatic run_pkt(input string nm, input int nbytes, input int pd_delay,
                           input bit silent, input bit gaps, input bit offer_next);
        logic [7:0]      pkt[$];
        logic [8*HB-1:0] exp_flat;
        int nbeats, exp_len, done_beat, b, since, fb;
        bit exp_full, done_seen, pd_sent, pd_now, acc, exp_rdy, exp_done, finished;
        pkt = {};
        for (int i = 0; i < nbytes; i++) pkt.push_back(8'($urandom));
        nbeats    = (nbytes + BB - 1) / BB;
        exp_len   = (nbytes > HB) ? HB : nbytes;
        exp_full  = (nbytes > HB);
        done_beat = (exp_len + BB - 1) / BB - 1;
        exp_flat  = '0;
        for (int i = 0; i < exp_len; i++) exp_flat[i*8 +: 8] = pkt[i];
        b = 0; since = 0; done_seen = 0; pd_sent = 0; finished = 0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            exp_rdy = !(b == nbeats && done_seen && !pd_sent);
            total++;
            if (s_tready !== exp_rdy) begin
                bad++;
                $display("FAIL %s_ready cyc=%0d got=%b want=%b", nm, cyc, s_tready, exp_rdy);
            end
            s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0; s_tdata = '0;
            if (b < nbeats) begin
                if (!gaps || $urandom_range(0, 3) != 0) begin
                    s_tvalid = 1'b1;
                    for (int k = 0; k < BB; k++) begin
                        if (b*BB + k < nbytes) begin
                            s_tkeep[k] = 1'b1;
                            s_tdata[k*8 +: 8] = pkt[b*BB + k];
                        end
                    end
                    s_tlast = (b == nbeats - 1);
                end
            end else if (offer_next) begin
                s_tvalid = 1'b1; s_tkeep = '1; s_tlast = 1'b1;
                s_tdata = {$urandom, $urandom};
            end
            pd_now     = done_seen && !pd_sent && (since == pd_delay);
            parse_done = pd_now && !silent;
            acc        = s_tvalid && s_tready;
            @(posedge clk);
            @(negedge clk);
            parse_done = 1'b0;
            exp_done = acc && (b < nbeats) && (b == done_beat);
            total++;
            if (header_done !== exp_done) begin
                bad++;
                $display("FAIL %s_done cyc=%0d got=%b want=%b", nm, cyc, header_done, exp_done);
            end
            if (acc && b < nbeats) b++;
            if (exp_done) begin
                done_seen = 1; since = 0;
                total++;
                if (hdr_len !== PW'(exp_len)) begin
                    bad++;
                    $display("FAIL %s_len got=%0d want=%0d", nm, hdr_len, exp_len);
                end
                total++;
                if (hdr_full !== exp_full) begin
                    bad++;
                    $display("FAIL %s_full got=%b want=%b", nm, hdr_full, exp_full);
                end
            end else if (done_seen) begin
                since++;
            end
            if (done_seen && !pd_sent && !pd_now) begin
                total++;
                if (header_flat !== exp_flat) begin
                    fb = 0;
                    for (int i = HB - 1; i >= 0; i--)
                        if (header_flat[i*8 +: 8] !== exp_flat[i*8 +: 8]) fb = i;
                    bad++;
                    $display("FAIL %s_flat cyc=%0d byte=%0d got=%h want=%h", nm, cyc, fb,
                             header_flat[fb*8 +: 8], exp_flat[fb*8 +: 8]);
                end
            end
            if (pd_now) pd_sent = 1;
            finished = done_seen && pd_sent && (b == nbeats);
        end
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tkeep = '0;
        total++;
        if (!finished) begin
            bad++;
            $display("FAIL %s_bound got=unfinished want=finished b=%0d", nm, b);
        end else begin
            if (header_flat !== '0 || hdr_len !== '0) begin
                bad++;
                $display("FAIL %s_release got=len%0d want=len0 flat0", nm, hdr_len);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (s_tready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", s_tready); end
        total++;
        if (header_done !== 1'b0 || hdr_full !== 1'b0 || timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b%b%b want=000", header_done, hdr_full, timeout_err);
        end
        total++;
        if (header_flat !== '0 || hdr_len !== '0) begin
            bad++; $display("FAIL reset_hdr got=len%0d want=len0", hdr_len);
        end
        rst_n = 1'b1;
        #1;
        total++;
        if (s_tready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", s_tready); end
        @(negedge clk);
    endtask

    task automatic test_short_64();
        run_pkt("p64", 64, 5, 0, 0, 0);
    endtask

    task automatic test_long_300_hold();
        run_pkt("p300", 300, 40, 0, 0, 0);
    endtask

    task automatic test_drain_pd();
        run_pkt("p300pd", 300, 10, 0, 0, 0);
    endtask

    task automatic test_back_to_back();
        run_pkt("p61", 61, 15, 0, 0, 1);
        run_pkt("p61b", 24, 2, 0, 0, 0);
    endtask

    task automatic test_reset_mid();
        for (int b = 0; b < 3; b++) begin
            s_tvalid = 1'b1; s_tkeep = '1; s_tlast = 1'b0;
            s_tdata = {$urandom, $urandom};
            if (b == 2) rst_n = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        s_tvalid = 1'b0;
        total++;
        if (header_flat !== '0 || hdr_len !== '0) begin
            bad++; $display("FAIL rstmid_hdr got=len%0d want=len0", hdr_len);
        end
        total++;
        if (header_done !== 1'b0 || hdr_full !== 1'b0 || s_tready !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_flags got=%b%b%b want=000", header_done, hdr_full, s_tready);
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_pkt("after_rst", 20, 4, 0, 0, 0);
    endtask

    task automatic test_empty();
        s_tvalid = 1'b1; s_tkeep = '0; s_tlast = 1'b1; s_tdata = {$urandom, $urandom};
        @(posedge clk);
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0;
        total++;
        if (header_done !== 1'b0 || s_tready !== 1'b1 || hdr_len !== '0) begin
            bad++;
            $display("FAIL empty_drop got=done%b rdy%b len%0d want=done0 rdy1 len0",
                     header_done, s_tready, hdr_len);
        end
        run_pkt("after_empty", 9, 1, 0, 0, 0);
    endtask

    task automatic test_pd_ignored();
        parse_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        parse_done = 1'b0;
        run_pkt("pd_idle", 200, 20, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            run_pkt("rnd", $urandom_range(1, 320), $urandom_range(0, 40), 0, 1, n[0]);
        end
`ifndef HDR_CAP_TIMEOUT_EN
        total++;
        if (timeout_err !== 1'b0) begin bad++; $display("FAIL rnd_tmo_err got=%b want=0", timeout_err); end
`endif
    endtask

`ifdef HDR_CAP_TIMEOUT_EN
    task automatic test_timeout();
        run_pkt("tmo", 64, PT - 1, 1, 0, 0);
        total++;
        if (timeout_err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b want=1", timeout_err); end
        run_pkt("tmo_next", 16, 3, 0, 0, 0);
    endtask
`endif

    initial begin
        s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
        parse_done = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        test_reset();
        test_short_64();
        test_long_300_hold();
        test_drain_pd();
        test_back_to_back();
        test_reset_mid();
        test_empty();
        test_pd_ignored();
        test_random();
`ifdef HDR_CAP_TIMEOUT_EN
        test_timeout();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
